// File: rtl/instr_fetch.sv
// instr_fetch: MIPS fetch stage. Owns the PC, drives the combinational imem and fills IF/ID.
// Define FETCH_PERF_CNT_EN to add the fetch_count output (number of valid IF/ID captures).
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic        misalign_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] pc_inc;
  logic [31:0] redirect_aligned;
  logic        valid_nxt;
  logic [31:0] instr_nxt;
  logic [31:0] ifid_pc_nxt;
  logic [31:0] ifid_pc_plus4_nxt;
  logic        misalign_nxt;
  logic        capture;

  assign pc_inc           = pc + PC_STEP;
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign imem_addr        = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Redirect beats halt beats stall in RUN; HALT still takes redirects but never captures.
  always_comb begin
    state_nxt         = state;
    pc_nxt            = pc;
    valid_nxt         = ifid_valid;
    instr_nxt         = ifid_instr;
    ifid_pc_nxt       = ifid_pc;
    ifid_pc_plus4_nxt = ifid_pc_plus4;
    misalign_nxt      = 1'b0;
    capture           = 1'b0;
    case (state)
      BOOT: begin
        state_nxt = halt_req ? HALT : RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          pc_nxt       = redirect_aligned;
          valid_nxt    = 1'b0;
          instr_nxt    = 32'h0000_0000;
          misalign_nxt = |redirect_pc[1:0];
        end else if (halt_req) begin
          valid_nxt = 1'b0;
          instr_nxt = 32'h0000_0000;
          state_nxt = HALT;
        end else if (!stall) begin
          capture           = 1'b1;
          valid_nxt         = 1'b1;
          instr_nxt         = imem_instr;
          ifid_pc_nxt       = pc;
          ifid_pc_plus4_nxt = pc_inc;
          pc_nxt            = pc_inc;
        end
      end
      HALT: begin
        valid_nxt = 1'b0;
        instr_nxt = 32'h0000_0000;
        if (redirect_valid) begin
          pc_nxt       = redirect_aligned;
          misalign_nxt = |redirect_pc[1:0];
        end
        state_nxt = halt_req ? HALT : RUN;
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= RESET_PC;
      ifid_valid    <= 1'b0;
      ifid_instr    <= 32'h0000_0000;
      ifid_pc       <= 32'h0000_0000;
      ifid_pc_plus4 <= 32'h0000_0000;
      misalign_err  <= 1'b0;
    end else begin
      pc            <= pc_nxt;
      ifid_valid    <= valid_nxt;
      ifid_instr    <= instr_nxt;
      ifid_pc       <= ifid_pc_nxt;
      ifid_pc_plus4 <= ifid_pc_plus4_nxt;
      misalign_err  <= misalign_nxt;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 32'h0000_0000;
    end else if (capture) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed test-plan sequences plus randomized traffic for instr_fetch,
// checked every cycle against a behavioural fetch model kept in this bench.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt_req = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  // Instruction memory contents are a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  instr_fetch #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt_req      (halt_req),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .ifid_valid    (ifid_valid),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .misalign_err  (misalign_err)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count)
`endif
  );

  // Behavioural model: what the fetch stage must show after each edge.
  logic [31:0] m_pc;
  bit          m_booting;
  bit          m_halted;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic [31:0] m_ipc4;
  bit          m_mis;
  int unsigned m_fetches;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = RESET_PC; m_booting = 1; m_halted = 0;
      m_valid = 0; m_instr = 0; m_ipc = 0; m_ipc4 = 0; m_mis = 0; m_fetches = 0;
    end else if (m_booting) begin
      m_booting = 0;
      m_halted  = halt_req;
      m_mis     = 0;
    end else begin
      m_mis = 0;
      if (m_halted) begin
        if (redirect_valid) begin
          m_pc  = redirect_pc & ~32'd3;
          m_mis = (redirect_pc % 4) != 0;
        end
        m_halted = halt_req;
      end else if (redirect_valid) begin
        m_pc    = redirect_pc & ~32'd3;
        m_mis   = (redirect_pc % 4) != 0;
        m_valid = 0;
        m_instr = 0;
      end else if (halt_req) begin
        m_valid  = 0;
        m_instr  = 0;
        m_halted = 1;
      end else if (!stall) begin
        m_valid   = 1;
        m_instr   = mem_word(m_pc);
        m_ipc     = m_pc;
        m_ipc4    = m_pc + 4;
        m_pc      = m_pc + 4;
        m_fetches = m_fetches + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("imem_addr", imem_addr, m_pc);
      checkOutput("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
      checkOutput("ifid_instr", ifid_instr, m_instr);
      checkOutput("ifid_pc", ifid_pc, m_ipc);
      checkOutput("ifid_pc_plus4", ifid_pc_plus4, m_ipc4);
      checkOutput("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
`ifdef FETCH_PERF_CNT_EN
      checkOutput("fetch_count", fetch_count, m_fetches);
`endif
    end
  end

  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rp, input logic h);
    stall          = s;
    redirect_valid = r;
    redirect_pc    = rp;
    halt_req       = h;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_addr"}, imem_addr, RESET_PC);
    checkOutput({tag, "_valid"}, {31'd0, ifid_valid}, 32'd0);
    checkOutput({tag, "_instr"}, ifid_instr, 32'd0);
    checkOutput({tag, "_pc"}, ifid_pc, 32'd0);
    checkOutput({tag, "_pc4"}, ifid_pc_plus4, 32'd0);
    checkOutput({tag, "_mis"}, {31'd0, misalign_err}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput({tag, "_cnt"}, fetch_count, 32'd0);
`endif
  endtask

  initial begin
    logic h;
    logic [31:0] rp;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    checkResetValues("reset");
    @(negedge clk); #2 rst = 1'b0;

    // BOOT edge: no capture, pc held.
    applyStimulus(0, 0, 0, 0);
    checkOutput("boot_valid", {31'd0, ifid_valid}, 32'd0);
    checkOutput("boot_addr", imem_addr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("seq_pc", ifid_pc, 32'(i * 4));
      checkOutput("seq_pc4", ifid_pc_plus4, 32'(i * 4 + 4));
      checkOutput("seq_instr", ifid_instr, mem_word(32'(i * 4)));
      checkOutput("seq_valid", {31'd0, ifid_valid}, 32'd1);
    end
    checkOutput("model_pc_after_seq", m_pc, 32'h0000_000C);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0);
      checkOutput("stall_pc", ifid_pc, 32'h08);
      checkOutput("stall_addr", imem_addr, 32'h0C);
      checkOutput("stall_instr", ifid_instr, mem_word(32'h08));
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("unstall_pc", ifid_pc, 32'h0C);

    applyStimulus(1, 1, 32'h1C, 0);
    checkOutput("redir_addr", imem_addr, 32'h1C);
    checkOutput("redir_valid", {31'd0, ifid_valid}, 32'd0);
    checkOutput("redir_mis", {31'd0, misalign_err}, 32'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("redir_ifid_pc", ifid_pc, 32'h1C);

    applyStimulus(0, 1, 32'h2E, 0);
    checkOutput("mis_addr", imem_addr, 32'h2C);
    checkOutput("mis_pulse", {31'd0, misalign_err}, 32'd1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("mis_clear", {31'd0, misalign_err}, 32'd0);
    checkOutput("mis_ifid_pc", ifid_pc, 32'h2C);

    applyStimulus(0, 1, 32'hFFFF_FFFC, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_pc4", ifid_pc_plus4, 32'h0000_0000);
    checkOutput("wrap_addr", imem_addr, 32'h0000_0000);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1);
      checkOutput("halt_valid", {31'd0, ifid_valid}, 32'd0);
      checkOutput("halt_addr", imem_addr, 32'h0);
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("unhalt_valid", {31'd0, ifid_valid}, 32'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("resume_pc", ifid_pc, 32'h0);
    checkOutput("resume_valid", {31'd0, ifid_valid}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("count_literal", fetch_count, 32'd8);
`endif
    checkOutput("model_fetches", m_fetches, 32'd8);

    applyStimulus(0, 1, 32'h40, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("prerst_addr", imem_addr, 32'h40);
    #2 rst = 1'b1;
    #1 checkResetValues("async_rst");
    @(negedge clk); #2 rst = 1'b0;

    h = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) h = ~h;
      rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, rp, h);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        #1 checkResetValues("rand_rst");
        @(negedge clk); #2 rst = 1'b0;
      end
    end

    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage of the MIPS core.
- Owns the program counter and drives the address of the combinational instruction memory.
- Captures the returned instruction word into the IF/ID pipeline register consumed by decode.
- Handles stall, branch/jump redirect, halt and PC wrap-around.

Parameters:
- RESET_PC, 32'h00000000: PC value loaded on reset; must be word aligned.
- PC_STEP, 4: byte increment per sequential fetch.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  decode hazard; hold PC and IF/ID contents.
- redirect_valid  in  1  taken branch/jump resolved downstream.
- redirect_pc  in  32  redirect target byte address.
- halt_req  in  1  level; stop fetching while high.
- imem_addr  out  32  address to instruction memory; equals pc combinationally.
- imem_instr  in  32  instruction word returned combinationally for imem_addr.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_instr  out  32  latched instruction; 32'h00000000 (NOP) when invalid.
- ifid_pc  out  32  address of ifid_instr.
- ifid_pc_plus4  out  32  ifid_pc + 4, for link and branch base.
- misalign_err  out  1  one-cycle pulse: redirect target had addr[1:0] != 0.

Behaviour:
- States: BOOT, RUN, HALT. Encoded in a 2-bit register.
- Reset (async, any time, including mid-redirect or mid-stall):
  - pc = RESET_PC; state = BOOT.
  - ifid_valid = 0; ifid_instr = 0; ifid_pc = 0; ifid_pc_plus4 = 0.
  - misalign_err = 0.
- BOOT:
  - Lasts exactly one cycle after rst deasserts; no IF/ID capture; pc held.
  - Next state is RUN, or HALT if halt_req is high.
- Per-edge priority in RUN, highest first:
  1. redirect_valid:
     - pc <= {redirect_pc[31:2], 2'b00}.
     - IF/ID squashed: valid 0, instr 0.
     - misalign_err <= (redirect_pc[1:0] != 0).
     - Overrides stall and halt_req for that edge.
  2. halt_req:
     - pc held; IF/ID squashed; state goes to HALT.
  3. stall:
     - pc and all IF/ID fields held unchanged.
  4. Otherwise:
     - ifid_instr <= imem_instr; ifid_pc <= pc; ifid_pc_plus4 <= pc + PC_STEP; ifid_valid <= 1.
     - pc <= pc + PC_STEP.
- HALT:
  - pc held; ifid_valid = 0.
  - redirect_valid is still accepted: pc is loaded, state stays HALT.
  - halt_req low at an edge returns to RUN; fetching resumes on the following edge.
- Fetch latency:
  - Instruction at pc appears on ifid_* one edge after pc is presented.
  - Sustained throughput is 1 instruction per cycle.
- Arithmetic:
  - All PC math is modulo 2^32. 32'hFFFFFFFC + 4 wraps to 32'h00000000, with no flag.
- misalign_err is 0 on every edge without a misaligned redirect.
- imem_instr is sampled only in the capture case and ignored otherwise.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- With the macro defined:
  - Adds output fetch_count (32-bit).
  - Reset value 0.
  - Increments on every edge where ifid_valid is loaded with 1.
  - Wraps at 2^32.
  - Holds during stall, halt and redirect.
- Without the macro: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0, imem holds words at 0x00, 0x04, 0x08:
  - BOOT cycle shows ifid_valid=0.
  - Next three edges give ifid_pc 0x00, 0x04, 0x08 with matching instr; ifid_pc_plus4 is 0x04, 0x08, 0x0C.
- Stall held 3 cycles while ifid_pc=0x08:
  - ifid_* and imem_addr=0x0C are frozen.
  - On release, the next ifid_pc is 0x0C; no instruction is lost or duplicated.
- redirect_valid with redirect_pc=0x1C while stall=1:
  - Next edge gives pc=0x1C and ifid_valid=0.
  - The following edge gives ifid_pc=0x1C.
- redirect_pc=0x2E:
  - pc becomes 0x2C; misalign_err is high for exactly one cycle.
- pc forced to 0xFFFFFFFC by redirect:
  - Captures ifid_pc=0xFFFFFFFC with ifid_pc_plus4=0x00000000; next pc=0x00000000.
- halt_req high 4 cycles, then low:
  - ifid_valid is 0 throughout; pc is unchanged.
  - Fetch resumes at the held pc.
  - Also assert rst mid-halt: all outputs return to reset values asynchronously.
  - With FETCH_PERF_CNT_EN, fetch_count equals the number of valid captures.
